repeat_delay_capture: RTL and testbench
=======================================

# repeat_delay_capture

Synthesizable counterpart of intra-assignment repeat event control (`lhs = repeat(n) @(posedge clk) rhs`). It captures a data word at acceptance time, holds it for a per-transaction number of rising clock edges, then presents it downstream. It sits directly upstream of the consumer that receives the delayed assignment, and supports up to DEPTH outstanding captures released in acceptance order.

## Interface
- DATA_W, 32, width of captured data
- CNT_W, 8, width of per-transaction repeat count
- DEPTH, 4, maximum outstanding captures (power of two, ≥2)

- clk  in  1  rising-edge clock; the only event counted
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  capture request
- in_ready  out  1  block can accept a request this cycle
- in_data  in  DATA_W  value captured at acceptance (the "RHS")
- in_count  in  CNT_W  repeat count n (0..2^CNT_W-1)
- out_valid  out  1  head entry matured and presentable
- out_ready  in  1  downstream accepts out_data
- out_data  out  DATA_W  captured value of head entry
- pending  out  $clog2(DEPTH+1)  number of stored entries
- busy  out  1  pending != 0

## Operation
- Storage: circular buffer of DEPTH slots, each {data, timer, used}; write pointer, read pointer, occupancy counter.
- Accept: in_valid && in_ready at an edge; in_data and in_count are sampled at that edge, and later changes are ignored.
- in_ready = (pending != DEPTH). There is no same-cycle bypass when full; a pop in the same cycle does not free space until the next cycle.
- Timer: every used slot with timer != 0 decrements by 1 at each edge after its acceptance edge. All slots run concurrently, including those behind the head. The timer saturates at 0.
- Maturity: a slot is matured when timer == 0.
- out_valid = head used && head timer == 0. out_data = head data, stable while out_valid && !out_ready.
- Pop: out_valid && out_ready at an edge. The read pointer advances and occupancy decrements.
- Release is strictly in acceptance order. A younger entry with a smaller count that matures first waits behind the head, then releases back-to-back.
- Simultaneous accept and pop: occupancy is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (rst high at an edge): all slots are cleared. Outputs are 0 in the following cycle: out_valid=0, out_data=0, pending=0, busy=0, in_ready=1.
- Reset mid-operation discards all outstanding entries without output. A request asserted in the same cycle as rst is not accepted.
- Latency: an entry accepted at edge E0 with count n, with an empty queue ahead, gives out_valid high in the cycle following edge E0+n.
  - n=0: next cycle (1-cycle latency).
  - n=3: after the third subsequent edge.
- If out_ready is held high, the entry is consumed at edge E0+n+1.
- pending updates in the cycle after the accepting or popping edge.
- Backpressure does not stall timers. Entries behind a stalled head keep counting down.
- in_count = 2^CNT_W-1 is legal; no overflow occurs, because the timer only decrements.

## Structure
- Package `repeat_delay_pkg`:
  - typedef `rdc_slot_t` (data, timer, used), parameterized through package parameters or localparams mirrored in the module
  - localparam `PTR_W` = $clog2(DEPTH)
- Sub-module `repeat_delay_slot`: one storage slot with load, decrement-to-zero timer and clear. It is instantiated DEPTH times via generate; the top holds pointers, occupancy and handshake logic.

## Test plan
- Single capture: in_data=42, in_count=3 at E0, in_data then changed to 7, out_ready=1 → out_valid first high after E3, out_data=42, consumed at E4, pending back to 0.
- Zero count: in_count=0, in_data=0xA5 at E0 → out_valid in the cycle after E0, out_data=0xA5.
- Order with mixed counts: accept (data=1,n=5) at E0 and (data=2,n=1) at E1 → 2 is held until 1 releases after E5; outputs 1 then 2 on consecutive cycles.
- Full and backpressure: out_ready=0, accept 4 entries with n=0 → in_ready=0, pending=4, out_data=first entry. Raise out_ready → one pop per cycle; in_ready returns the cycle after the first pop.
- Reset mid-operation: 3 entries pending with n=10, rst pulse at E2 → pending=0, out_valid=0 and never asserts for the dropped entries. A new capture (n=2, data=9) then releases after 2 edges.
- Max count: in_count=255, data=0xFF → out_valid after exactly 255 edges, not before.

Source files
------------

// File: rtl/repeat_delay_pkg.sv
// Shared widths, slot record and helpers for the repeat-delay capture queue.
package repeat_delay_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 8;
  localparam int DEPTH  = 4;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int OCC_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  timer;
    logic              used;
  } rdc_slot_t;

  // A slot may be presented once it holds data and its delay has elapsed.
  function automatic logic slot_matured(rdc_slot_t s);
    return s.used && (s.timer == '0);
  endfunction

endpackage

// File: rtl/repeat_delay_capture_if.sv
// Capture-side and release-side handshake bundle of the repeat-delay queue.
interface repeat_delay_capture_if;
  import repeat_delay_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CNT_W-1:0]  in_count;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [OCC_W-1:0]  pending;
  logic              busy;

  modport master (
    output in_valid, in_data, in_count, out_ready,
    input  in_ready, out_valid, out_data, pending, busy
  );

  modport slave (
    input  in_valid, in_data, in_count, out_ready,
    output in_ready, out_valid, out_data, pending, busy
  );

endinterface

// File: rtl/repeat_delay_slot.sv
// One queue slot: holds a captured word and counts its delay down to zero.
module repeat_delay_slot
  import repeat_delay_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] load_data,
  input  logic [CNT_W-1:0]  load_count,
  output rdc_slot_t         slot
);

  // Load wins; otherwise the timer runs regardless of head position or backpressure.
  // A clear only ever hits a matured slot, so clearing and counting never interact.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot <= '0;
    end else if (load) begin
      slot.data  <= load_data;
      slot.timer <= load_count;
      slot.used  <= 1'b1;
    end else begin
      if (clear) begin
        slot.used <= 1'b0;
      end
      if (slot.used && (slot.timer != '0)) begin
        slot.timer <= slot.timer - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/repeat_delay_capture.sv
// In-order delay queue: each accepted word is released after its own edge count.
module repeat_delay_capture
  import repeat_delay_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  repeat_delay_capture_if.slave  bus
);

  rdc_slot_t        slots [DEPTH];
  rdc_slot_t        head;
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [OCC_W-1:0] occ;
  logic             accept;
  logic             pop;

  // No bypass when full: space freed by a pop only shows up the next cycle.
  assign head          = slots[rptr];
  assign bus.in_ready  = (occ != OCC_W'(DEPTH));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = slot_matured(head);
  assign pop           = bus.out_valid && bus.out_ready;
  assign bus.out_data  = head.data;
  assign bus.pending   = occ;
  assign bus.busy      = (occ != '0);

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    repeat_delay_slot u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (accept && (wptr == PTR_W'(i))),
      .clear      (pop && (rptr == PTR_W'(i))),
      .load_data  (bus.in_data),
      .load_count (bus.in_count),
      .slot       (slots[i])
    );
  end

  // Pointers wrap naturally (DEPTH is a power of two); occupancy tracks accept/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      occ  <= '0;
    end else begin
      if (accept) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop) begin
        rptr <= rptr + PTR_W'(1);
      end
      case ({accept, pop})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_repeat_delay_capture.sv
// Directed bench: vector table for the basic flows, hand sequences for the long cases.
module tb_repeat_delay_capture;

  logic clk;
  logic rst;

  repeat_delay_capture_if bus ();

  repeat_delay_capture dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          rst;
    bit          iv;
    logic [31:0] d;
    logic [7:0]  n;
    bit          ordy;
    bit          ev;
    bit          chkd;
    logic [31:0] ed;
    int          ep;
    bit          erdy;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(string name, bit r, bit iv, logic [31:0] d, logic [7:0] n,
                              bit ordy, bit ev, bit chkd, logic [31:0] ed, int ep, bit erdy);
    vec_t v;
    v.name = name; v.rst = r; v.iv = iv; v.d = d; v.n = n; v.ordy = ordy;
    v.ev = ev; v.chkd = chkd; v.ed = ed; v.ep = ep; v.erdy = erdy;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(bit r, bit iv, logic [31:0] d, logic [7:0] n, bit ordy);
    rst          = r;
    bus.in_valid = iv;
    bus.in_data  = d;
    bus.in_count = n;
    bus.out_ready = ordy;
  endtask

  task automatic check_state(string nm, bit ev, bit chkd, logic [31:0] ed, int ep, bit erdy);
    check({nm, ".out_valid"}, 64'(bus.out_valid), 64'(ev));
    check({nm, ".pending"},   64'(bus.pending),   64'(ep));
    check({nm, ".busy"},      64'(bus.busy),      64'(ep != 0));
    check({nm, ".in_ready"},  64'(bus.in_ready),  64'(erdy));
    if (chkd) check({nm, ".out_data"}, 64'(bus.out_data), 64'(ed));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;

    // reset, single capture (n=3, data changed after accept), zero count, mixed-count order
    vecs.push_back(mk("reset", 1, 0, 0,      0, 0, 0, 1, 0,      0, 1));
    vecs.push_back(mk("s_e0",  0, 1, 42,     3, 1, 0, 0, 0,      1, 1));
    vecs.push_back(mk("s_e1",  0, 0, 7,      3, 1, 0, 0, 0,      1, 1));
    vecs.push_back(mk("s_e2",  0, 0, 7,      3, 1, 0, 0, 0,      1, 1));
    vecs.push_back(mk("s_e3",  0, 0, 7,      0, 1, 1, 1, 42,     1, 1));
    vecs.push_back(mk("s_e4",  0, 0, 0,      0, 1, 0, 0, 0,      0, 1));
    vecs.push_back(mk("z_e0",  0, 1, 'hA5,   0, 0, 1, 1, 'hA5,   1, 1));
    vecs.push_back(mk("z_e1",  0, 0, 0,      0, 1, 0, 0, 0,      0, 1));
    vecs.push_back(mk("o_e0",  0, 1, 1,      5, 1, 0, 0, 0,      1, 1));
    vecs.push_back(mk("o_e1",  0, 1, 2,      1, 1, 0, 0, 0,      2, 1));
    vecs.push_back(mk("o_e2",  0, 0, 0,      0, 1, 0, 0, 0,      2, 1));
    vecs.push_back(mk("o_e3",  0, 0, 0,      0, 1, 0, 0, 0,      2, 1));
    vecs.push_back(mk("o_e4",  0, 0, 0,      0, 1, 0, 0, 0,      2, 1));
    vecs.push_back(mk("o_e5",  0, 0, 0,      0, 1, 1, 1, 1,      2, 1));
    vecs.push_back(mk("o_e6",  0, 0, 0,      0, 1, 1, 1, 2,      1, 1));
    vecs.push_back(mk("o_e7",  0, 0, 0,      0, 1, 0, 0, 0,      0, 1));

    drive(1, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].iv, vecs[i].d, vecs[i].n, vecs[i].ordy);
      tick();
      check_state(vecs[i].name, vecs[i].ev, vecs[i].chkd, vecs[i].ed, vecs[i].ep, vecs[i].erdy);
    end

    // Full with backpressure, blocked request while full, accept+pop, wrap.
    for (int k = 0; k < 4; k++) begin
      drive(0, 1, 32'h10 + 32'(k), 0, 0);
      tick();
    end
    check_state("full", 1, 1, 32'h10, 4, 0);
    drive(0, 1, 32'h99, 0, 1);
    tick();
    check_state("full_pop1", 1, 1, 32'h11, 3, 1);
    drive(0, 1, 32'h20, 0, 1);
    tick();
    check_state("acc_pop", 1, 1, 32'h12, 3, 1);
    drive(0, 0, 0, 0, 1);
    tick();
    check_state("drain1", 1, 1, 32'h13, 2, 1);
    tick();
    check_state("drain2", 1, 1, 32'h20, 1, 1);
    tick();
    check_state("drain3", 0, 0, 0, 0, 1);

    // Reset with three long-delay entries outstanding; request during reset is dropped.
    for (int k = 0; k < 3; k++) begin
      drive(0, 1, 32'h31 + 32'(k), 10, 1);
      tick();
    end
    check_state("pre_rst", 0, 0, 0, 3, 1);
    drive(1, 1, 32'h33, 10, 1);
    tick();
    check_state("mid_rst", 0, 1, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    seen = 0;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (bus.out_valid !== 1'b0 || bus.pending !== '0) seen++;
    end
    check("rst_dropped_silent", 64'(seen), 64'd0);
    drive(0, 1, 9, 2, 1);
    tick();
    check_state("post_e0", 0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 1);
    tick();
    check_state("post_e1", 0, 0, 0, 1, 1);
    tick();
    check_state("post_e2", 1, 1, 9, 1, 1);
    tick();
    check_state("post_e3", 0, 0, 0, 0, 1);

    // Maximum count: matures after exactly 255 edges.
    drive(0, 1, 32'hFF, 8'd255, 1);
    tick();
    drive(0, 0, 0, 0, 1);
    seen = 0;
    for (int k = 1; k < 255; k++) begin
      tick();
      if (bus.out_valid !== 1'b0) seen++;
    end
    check("max_not_early", 64'(seen), 64'd0);
    check_state("max_hold", 0, 0, 0, 1, 1);
    tick();
    check_state("max_e255", 1, 1, 32'hFF, 1, 1);
    tick();
    check_state("max_pop", 0, 0, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
